// File: rtl/t_stream_gen_if.sv
// Host base-write port and target token stream of t_stream_gen, bundled for
// connection between the host side (master) and the generator (slave).
interface t_stream_gen_if;
    logic       en;
    logic       in_valid;
    logic [1:0] in_base;
    logic       in_last;
    logic       in_ready;
    logic [2:0] t_o;
    logic       busy;
    logic       done;
    logic [7:0] seq_len;

    modport master (
        output en, in_valid, in_base, in_last,
        input  in_ready, t_o, busy, done, seq_len
    );

    modport slave (
        input  en, in_valid, in_base, in_last,
        output in_ready, t_o, busy, done, seq_len
    );
endinterface

// File: rtl/t_stream_gen.sv
// Buffers host-written bases and frames each complete target sequence as a
// registered token stream: start marker, one token per base, end marker.
module t_stream_gen #(
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    t_stream_gen_if.slave bus
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [2:0]    TOK_BUB  = 3'b000;
    localparam logic [2:0]    TOK_STA  = 3'b001;
    localparam logic [2:0]    TOK_END  = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_END
    } state_t;

    // Length counter stops at 255 instead of wrapping for very long targets.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   pending;
    logic          full;
    logic          empty;
    logic          wr_en;
    logic          pop;
    logic [2:0]    head;
    logic          wr_last;
    logic          pop_last;

    state_t        state_q;
    state_t        state_d;
    logic [2:0]    tok_p1;
    logic [2:0]    tok_d;
    logic          done_p1;
    logic          done_d;
    logic [7:0]    len_q;
    logic [7:0]    len_d;
    logic [7:0]    seq_len_q;
    logic [7:0]    seq_len_d;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign wr_en    = bus.in_valid && !full;
    assign head     = mem[rd_ptr];
    assign wr_last  = wr_en && bus.in_last;
    assign pop_last = pop && head[2];

    // Stage p0: base buffer, entries stored as {last, base}
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {bus.in_last, bus.in_base};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            pending <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // pending tracks complete sequences still held in the buffer
            case ({wr_last, pop_last})
                2'b10:   pending <= pending + 1'b1;
                2'b01:   pending <= pending - 1'b1;
                default: pending <= pending;
            endcase
        end
    end

    // Emit FSM: with en low nothing advances and a bubble is driven.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        tok_d     = TOK_BUB;
        done_d    = 1'b0;
        len_d     = len_q;
        seq_len_d = seq_len_q;
        if (bus.en) begin
            case (state_q)
                S_IDLE: begin
                    // a full buffer must start draining even without a last flag
                    if ((pending != '0) || full) begin
                        state_d = S_START;
                    end
                end
                S_START: begin
                    tok_d   = TOK_STA;
                    state_d = S_DATA;
                end
                S_DATA: begin
                    if (!empty) begin
                        pop   = 1'b1;
                        tok_d = {1'b1, head[1:0]};
                        len_d = sat_inc(len_q);
                        if (head[2]) begin
                            state_d = S_END;
                        end
                    end
                end
                S_END: begin
                    tok_d     = TOK_END;
                    done_d    = 1'b1;
                    seq_len_d = len_q;
                    len_d     = '0;
                    state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Stage p1: registered token, done pulse and sequence length
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tok_p1    <= TOK_BUB;
            done_p1   <= 1'b0;
            len_q     <= '0;
            seq_len_q <= '0;
        end else begin
            state_q   <= state_d;
            tok_p1    <= tok_d;
            done_p1   <= done_d;
            len_q     <= len_d;
            seq_len_q <= seq_len_d;
        end
    end

    assign bus.in_ready = !full;
    assign bus.t_o      = tok_p1;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_p1;
    assign bus.seq_len  = seq_len_q;
endmodule

// File: tb/tb_t_stream_gen.sv
// Scoreboard bench for t_stream_gen: directed framing/timing scenarios plus
// randomized host traffic checked against a sequence-level token model.
module tb_t_stream_gen;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    t_stream_gen_if bus();

    t_stream_gen #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: each complete sequence becomes 001, one 1bb per base, 010.
    logic [2:0] exp_tok[$];
    logic [7:0] exp_len[$];
    bit         in_seq    = 1'b0;
    int         cur_n     = 0;
    int         accepted  = 0;
    int         bases_out = 0;

    logic [2:0] tr_tok[$];
    logic       tr_done[$];
    logic [7:0] tr_len[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: got timeout, expected event (t=%0t)", name, $time);
    endtask

    task automatic model_accept(input logic [1:0] b, input logic l);
        if (!in_seq) begin
            exp_tok.push_back(3'b001);
            in_seq = 1'b1;
            cur_n  = 0;
        end
        exp_tok.push_back({1'b1, b});
        if (cur_n < 255) cur_n++;
        accepted++;
        if (l) begin
            exp_tok.push_back(3'b010);
            exp_len.push_back(8'(cur_n));
            in_seq = 1'b0;
        end
    endtask

    task automatic model_flush();
        exp_tok.delete();
        exp_len.delete();
        in_seq    = 1'b0;
        cur_n     = 0;
        accepted  = 0;
        bases_out = 0;
    endtask

    // Main process acts 2 time units after each rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wr1(input logic [1:0] b, input logic l);
        cyc();
        bus.in_valid = 1'b1;
        bus.in_base  = b;
        bus.in_last  = l;
        chk("wr_ready", bus.in_ready, 1);
        if (bus.in_ready) model_accept(b, l);
    endtask

    task automatic send_base(input logic [1:0] b, input logic l);
        bit sent  = 1'b0;
        int guard = 0;
        while (!sent) begin
            cyc();
            bus.en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_base  = b;
                bus.in_last  = l;
                if (bus.in_ready) begin
                    model_accept(b, l);
                    sent = 1'b1;
                end
            end
            guard++;
            if (!sent && guard > 2000) begin
                fail_now("send_timeout");
                sent = 1'b1;
            end
        end
    endtask

    task automatic drain();
        int t = 0;
        cyc();
        bus.in_valid = 1'b0;
        bus.en       = 1'b1;
        while ((exp_tok.size() != 0 || bus.busy) && t < 3000) begin
            cyc();
            t++;
        end
        if (t >= 3000) fail_now("drain_timeout");
        repeat (3) cyc();
    endtask

    task automatic trace(input int n);
        int t = 0;
        tr_tok.delete();
        tr_done.delete();
        tr_len.delete();
        do begin
            cyc();
            bus.in_valid = 1'b0;
            t++;
        end while (bus.t_o == 3'b000 && t < 60);
        if (bus.t_o == 3'b000) fail_now("trace_timeout");
        for (int i = 0; i < n; i++) begin
            if (i > 0) cyc();
            tr_tok.push_back(bus.t_o);
            tr_done.push_back(bus.done);
            tr_len.push_back(bus.seq_len);
        end
    endtask

    // Monitor: compares every non-bubble token, done pulse and in_ready.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (bus.t_o != 3'b000) begin
                    if (bus.t_o[2]) bases_out++;
                    if (exp_tok.size() == 0) chk("stream_extra", bus.t_o, 3'b000);
                    else chk("stream_tok", bus.t_o, exp_tok.pop_front());
                end
                if (bus.done || bus.t_o == 3'b010) chk("done_with_end", bus.done, (bus.t_o == 3'b010));
                if (bus.done) begin
                    if (exp_len.size() == 0) fail_now("seq_len_unexpected");
                    else chk("seq_len", bus.seq_len, exp_len.pop_front());
                end
                chk("in_ready", bus.in_ready, ((accepted - bases_out) < DEPTH));
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb;
        logic [2:0] exp029 [6] = '{3'b001, 3'b110, 3'b100, 3'b111, 3'b010, 3'b000};
        logic [2:0] exp031 [8] = '{3'b001, 3'b101, 3'b110, 3'b010, 3'b000, 3'b001, 3'b111, 3'b010};

        bus.en       = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_base  = 2'b00;
        bus.in_last  = 1'b0;

        // Reset state
        repeat (3) cyc();
        chk("rst_t_o", bus.t_o, 3'b000);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_seq_len", bus.seq_len, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        rst    = 1'b0;
        bus.en = 1'b1;

        // Single-base sequence: start marker two edges after the write
        wr1(2'b00, 1'b1);
        cyc();
        bus.in_valid = 1'b0;
        chk("lat_e0_t_o", bus.t_o, 3'b000);
        chk("lat_e0_busy", bus.busy, 0);
        cyc();
        chk("lat_e1_t_o", bus.t_o, 3'b000);
        chk("lat_e1_busy", bus.busy, 1);
        cyc();
        chk("lat_e2_start", bus.t_o, 3'b001);
        drain();
        chk("single_seq_len", bus.seq_len, 1);

        // G, A, T(last): exact framing including the trailing bubble
        wr1(2'b10, 1'b0);
        wr1(2'b00, 1'b0);
        wr1(2'b11, 1'b1);
        trace(6);
        for (int i = 0; i < 6; i++) chk($sformatf("gat_tok%0d", i), tr_tok[i], exp029[i]);
        chk("gat_done3", tr_done[3], 0);
        chk("gat_done4", tr_done[4], 1);
        chk("gat_done5", tr_done[5], 0);
        chk("gat_len4", tr_len[4], 3);
        drain();

        // Two sequences (C,G) and (T) buffered back-to-back
        wr1(2'b01, 1'b0);
        wr1(2'b10, 1'b1);
        wr1(2'b11, 1'b1);
        trace(8);
        for (int i = 0; i < 8; i++) chk($sformatf("b2b_tok%0d", i), tr_tok[i], exp031[i]);
        drain();
        repeat (4) begin
            cyc();
            chk("b2b_idle_busy", bus.busy, 0);
        end

        // en dropped for three cycles in DATA
        wr1(2'b01, 1'b0);
        wr1(2'b11, 1'b0);
        wr1(2'b00, 1'b1);
        nb = 0;
        for (int t = 0; t < 60 && nb == 0; t++) begin
            cyc();
            bus.in_valid = 1'b0;
            if (bus.t_o[2]) nb++;
        end
        chk("en_first_base", bus.t_o, 3'b101);
        bus.en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("en_off_t_o", bus.t_o, 3'b000);
            chk("en_off_busy", bus.busy, 1);
        end
        bus.en = 1'b1;
        cyc();
        chk("en_resume", bus.t_o, 3'b111);
        drain();
        chk("en_seq_len", bus.seq_len, 3);

        // DEPTH bases without last: full triggers start, bubbles while empty
        for (int i = 0; i < DEPTH; i++) wr1(2'(i % 4), 1'b0);
        cyc();
        bus.in_valid = 1'b0;
        chk("full_in_ready", bus.in_ready, 0);
        repeat (DEPTH + 8) cyc();
        chk("empty_bubble_t_o", bus.t_o, 3'b000);
        chk("empty_bubble_busy", bus.busy, 1);
        wr1(2'b10, 1'b1);
        drain();
        chk("long_seq_len", bus.seq_len, DEPTH + 1);

        // Reset during DATA after two bases
        wr1(2'b00, 1'b0);
        wr1(2'b01, 1'b0);
        wr1(2'b10, 1'b0);
        wr1(2'b11, 1'b1);
        nb = 0;
        for (int t = 0; t < 60 && nb < 2; t++) begin
            cyc();
            bus.in_valid = 1'b0;
            if (bus.t_o[2]) nb++;
        end
        chk("rst_pre_bases", nb, 2);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_t_o", bus.t_o, 3'b000);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_done", bus.done, 0);
        model_flush();
        cyc();
        rst = 1'b0;
        repeat (6) begin
            cyc();
            chk("postrst_t_o", bus.t_o, 3'b000);
            chk("postrst_busy", bus.busy, 0);
            chk("postrst_done", bus.done, 0);
        end

        // Randomized traffic with random en and write gaps
        for (int s = 0; s < 40; s++) begin
            int n;
            n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(DEPTH, DEPTH + 5))
                                            : int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) send_base(2'($urandom_range(0, 3)), (i == n - 1));
        end
        drain();
        chk("final_exp_empty", exp_len.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/t_stream_gen.md
T_STREAM_GEN -- requirements
Module: t_stream_gen

Interface
REQ-001 Parameter DEPTH, default 16, base-buffer entries (power of 2, 4..64).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 en  input  1  stream enable; low freezes the emit FSM.
REQ-005 in_valid  input  1  host base write request.
REQ-006 in_base  input  2  base code: 00=A, 01=C, 10=G, 11=T.
REQ-007 in_last  input  1  marks final base of a target sequence.
REQ-008 in_ready  output  1  buffer can accept a base (= not full).
REQ-009 t_o  output  3  registered token to the first target shift stage.
REQ-010 busy  output  1  FSM not in IDLE.
REQ-011 done  output  1  one-cycle pulse, coincident with end token on t_o.
REQ-012 seq_len  output  8  bases emitted in the last completed sequence.

Function
REQ-013 Token encoding on t_o SHALL be: 000 bubble, 001 start marker, 010 end marker, 1bb base (bb = base code); 011 SHALL never be emitted.
REQ-014 Buffer: DEPTH-entry FIFO of {last, base}; write when in_valid && in_ready; in_ready = !full; no write bypass when full, even with a same-cycle pop.
REQ-015 Pending counter SHALL count complete sequences in the FIFO: +1 on write with in_last, -1 on pop of a last-flagged entry, unchanged when both occur in one cycle.
REQ-016 FSM states IDLE, START, DATA, END; while en=0 state holds and t_o is driven 000, no pops.
REQ-017 IDLE -> START when en=1 and (pending > 0 or FIFO full); START cycle registers t_o=001.
REQ-018 START -> DATA unconditionally next cycle.
REQ-019 DATA: if FIFO non-empty, pop one entry and register t_o={1,base}, increment length counter (saturate 255); if popped entry has last=1 -> END.
REQ-020 DATA with FIFO empty (sequence longer than DEPTH, host slow): register t_o=000, stay in DATA, no count.
REQ-021 END: register t_o=010, done=1, seq_len <= length counter; then -> IDLE, clearing length counter.
REQ-022 IDLE always emits at least one t_o=000 cycle between sequences; no END->START direct path.
REQ-023 Latency: first start marker on t_o two clock edges after the write of a last-flagged base into an otherwise empty FIFO in IDLE with en=1.
REQ-024 A sequence with a single base SHALL yield exactly 001, 1bb, 010, seq_len=1.
REQ-025 Host writes during emission are accepted normally; pointers wrap modulo DEPTH.
REQ-026 busy = (state != IDLE), combinational from state register.

Reset
REQ-027 On rst: state IDLE, FIFO empty, pending=0, length counter=0, t_o=000, done=0, seq_len=0; in_ready=1 after reset.
REQ-028 Reset asserted mid-sequence SHALL discard buffered bases; no end marker emitted.

Verification
REQ-029 Write G,A,T(last) with en=1 -> t_o sequence 001,110,100,111,010, done pulse with 010, seq_len=3, then 000.
REQ-030 Write DEPTH bases, none last -> in_ready=0, start emitted on full; later base with last after drain -> bubbles 000 while empty, then 1bb, 010, seq_len=DEPTH+1.
REQ-031 Two complete sequences (2 and 1 bases) buffered back-to-back -> 001,1xx,1xx,010,000,001,1xx,010; pending returns to 0.
REQ-032 Drop en for 3 cycles in DATA -> t_o=000 for those cycles, no pops, emission resumes with the next base, seq_len unaffected.
REQ-033 Assert rst during DATA after 2 bases -> t_o=000 next edge-independent, busy=0, FIFO empty, no done pulse.
